ws2812_frame_sched: RTL and testbench

- Frame-rate controller that sequences a WS2812 chain.
- Generates one rainbow frame per frame-timer tick: NUM_LEDS 24-bit colour words, each with a hue offset, streamed to the WS2812 bit serializer over a valid/ready handshake.
- Advances the base hue every frame and waits for the serializer's reset gap before declaring the frame done.
- Sits between top-level control (enable, speed, brightness) and the existing serializer.

---
 rtl/ws2812_frame_sched_pkg.sv | 16 +
 rtl/ws2812_frame_sched_if.sv | 10 +
 rtl/ws2812_frame_sched_hue_to_grb.sv | 25 ++
 rtl/ws2812_frame_sched.sv | 80 ++++++++
 tb/tb_ws2812_frame_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ws2812_frame_sched_pkg.sv
// ws2812_pkg: shared constants, state encoding and hue arithmetic for the WS2812 frame scheduler
package ws2812_pkg;
    localparam int HUE_MAX = 768;
    localparam int CLK_FRE = 27000000;
    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_LATCH} state_t;

    function automatic logic [9:0] hue_add(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 11'(HUE_MAX)) ? 10'(s - 11'(HUE_MAX)) : s[9:0];
    endfunction
endpackage

// File: rtl/ws2812_frame_sched_if.sv
// ws2812_frame_sched_if: pixel word stream from the scheduler to the WS2812 serializer
interface ws2812_frame_sched_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_last;
    logic        pix_ready;

    modport master(output pix_data, pix_valid, pix_last, input pix_ready);
    modport slave(input pix_data, pix_valid, pix_last, output pix_ready);
endinterface

// File: rtl/ws2812_frame_sched_hue_to_grb.sv
// ws2812_hue_to_grb: three-segment rainbow hue (0..767) to dimmed GRB colour word
module ws2812_hue_to_grb
    import ws2812_pkg::*;
(
    input  logic [9:0]  hue,
    input  logic [2:0]  bright_shift,
    output logic [23:0] grb
);
    logic [1:0] seg;
    logic [7:0] f, dn, r, g, b;

    assign seg = hue[9:8];
    assign f   = hue[7:0];
    assign dn  = ~f;

    always_comb begin
        r = (seg == 2'd0) ? dn : (seg == 2'd2) ? f : 8'd0;
        g = (seg == 2'd0) ? f : (seg == 2'd1) ? dn : 8'd0;
        b = (seg == 2'd1) ? f : (seg == 2'd2) ? dn : 8'd0;
        grb = '0;
        grb[G_LSB +: 8] = g >> bright_shift;
        grb[R_LSB +: 8] = r >> bright_shift;
        grb[B_LSB +: 8] = b >> bright_shift;
    end
endmodule

// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: per-tick rainbow frame generator feeding a WS2812 serializer
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int HUE_STEP    = 32,
    parameter int FRAME_TICKS = 270000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [7:0]                  hue_speed,
    input  logic [2:0]                  bright_shift,
    ws2812_frame_sched_if.master        pix,
    input  logic                        ser_idle,
    output logic                        frame_done,
    output logic                        frame_overrun,
    output logic                        busy
);
    localparam int TW = $clog2(FRAME_TICKS);
    localparam int IW = $clog2(NUM_LEDS + 1);

    state_t         state, nxt;
    logic [TW-1:0]  timer;
    logic [IW-1:0]  idx;
    logic [9:0]     base_hue, pix_hue, hue_next;
    logic [23:0]    grb;
    logic           tick, start, xfer, last_xfer, finish;

    assign tick      = timer == TW'(FRAME_TICKS - 1);
    assign start     = state == IDLE && tick && enable;
    assign xfer      = pix.pix_valid && pix.pix_ready;
    assign last_xfer = xfer && idx == IW'(NUM_LEDS - 1);
    assign finish    = state == WAIT_LATCH && ser_idle;
    // The word loaded into pix_data is always the colour of the hue being loaded into pix_hue
    assign hue_next  = start ? base_hue : hue_add(pix_hue, 10'(HUE_STEP));

    ws2812_hue_to_grb u_hue (.hue(hue_next), .bright_shift(bright_shift), .grb(grb));

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:       nxt = start ? STREAM : IDLE;
            STREAM:     nxt = last_xfer ? WAIT_LATCH : STREAM;
            WAIT_LATCH: nxt = ser_idle ? IDLE : WAIT_LATCH;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) state <= rst ? IDLE : nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer         <= '0;
            idx           <= '0;
            base_hue      <= '0;
            pix_hue       <= '0;
            pix.pix_data  <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_last  <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
            busy          <= 1'b0;
        end else begin
            timer         <= tick ? '0 : timer + TW'(1);
            frame_done    <= finish;
            frame_overrun <= tick && state != IDLE;
            busy          <= nxt != IDLE;
            pix.pix_valid <= nxt == STREAM;
            if (finish)
                base_hue <= hue_add(base_hue, {2'b00, hue_speed});
            if (start || xfer) begin
                pix_hue      <= hue_next;
                pix.pix_data <= grb;
                idx          <= start ? '0 : idx + IW'(1);
                pix.pix_last <= start ? (NUM_LEDS == 1) : (idx + IW'(1) == IW'(NUM_LEDS - 1));
            end
        end
    end
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// tb_ws2812_frame_sched: directed and randomized checks of the frame scheduler against a hue-arithmetic model
module tb_ws2812_frame_sched;
    localparam int N     = 4;
    localparam int STEP  = 64;
    localparam int TICKS = 100;

    logic       clk = 1'b0;
    logic       rst, enable, ser_idle, frame_done, frame_overrun, busy;
    logic [7:0] hue_speed;
    logic [2:0] bright_shift;

    ws2812_frame_sched_if bus();

    ws2812_frame_sched #(.NUM_LEDS(N), .HUE_STEP(STEP), .FRAME_TICKS(TICKS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .hue_speed(hue_speed),
        .bright_shift(bright_shift), .pix(bus), .ser_idle(ser_idle),
        .frame_done(frame_done), .frame_overrun(frame_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int k = 0, base = 0, done_cnt = 0, ovr_cnt = 0, vcnt = 0;
    logic [23:0] first_pix = '0;
    logic [7:0]  spd_q = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] col(input int h, input int sh);
        int seg, f, r, g, b;
        seg = h / 256;
        f   = h % 256;
        r   = seg == 0 ? 255 - f : seg == 2 ? f : 0;
        g   = seg == 0 ? f : seg == 1 ? 255 - f : 0;
        b   = seg == 1 ? f : seg == 2 ? 255 - f : 0;
        return {8'(g >> sh), 8'(r >> sh), 8'(b >> sh)};
    endfunction

    always @(posedge clk) spd_q <= hue_speed;

    // Reference: pixel k of a frame has hue (base + k*STEP) mod 768; base advances by hue_speed per completed frame
    always @(negedge clk) begin
        if (rst) begin
            k    = 0;
            base = 0;
        end else begin
            if (bus.pix_valid) begin
                chk("pix_data", 32'(bus.pix_data), 32'(col((base + k * STEP) % 768, int'(bright_shift))));
                chk("pix_last", 32'(bus.pix_last), 32'(k == N - 1));
                chk("busy_stream", 32'(busy), 32'd1);
                vcnt++;
                if (bus.pix_ready) begin
                    if (k == 0) first_pix = bus.pix_data;
                    k = (k == N - 1) ? 0 : k + 1;
                end
            end
            if (frame_done) begin
                chk("done_after_last", 32'(k), 32'd0);
                done_cnt++;
                base = (base + int'(spd_q)) % 768;
            end
            if (frame_overrun) ovr_cnt++;
        end
    end

    task automatic wait_done(input int budget, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = frame_done;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_pix(input int kk, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            ok = k == kk && bus.pix_valid;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, d0, v0, target;
        logic ok;
        rst = 1'b1; enable = 1'b1; hue_speed = '0; bright_shift = '0;
        bus.pix_ready = 1'b1; ser_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_last", 32'(bus.pix_last), 32'd0);
        chk("rst_data", 32'(bus.pix_data), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ovr", 32'(frame_overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        v0 = vcnt;
        wait_done(300, "frame0_done");
        chk("frame0_words", 32'(vcnt - v0), 32'd4);
        chk("frame0_pix0", 32'(first_pix), 32'h00FF00);

        bright_shift = 3'd1;
        wait_done(250, "shift_done");
        chk("shift_pix0", 32'(first_pix), 32'h007F00);

        bright_shift = 3'd0;
        hue_speed = 8'd10;
        for (int i = 0; i < 78; i++) wait_done(250, "speed_done");
        chk("wrap_pix0", 32'(first_pix), 32'h02FD00);

        hue_speed = 8'd0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_pix(2, "stall_reach");
        bus.pix_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.pix_valid), 32'd1);
            chk("stall_data", 32'(bus.pix_data), 32'h807F00);
        end
        bus.pix_ready = 1'b1;
        wait_done(250, "stall_done");

        ser_idle = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            ok = busy && !bus.pix_valid;
        end
        chk("latch_reach", 32'(ok), 32'd1);
        o0 = ovr_cnt; d0 = done_cnt; v0 = vcnt;
        repeat (150) @(posedge clk);
        #1;
        chk("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("latch_no_done", 32'(done_cnt - d0), 32'd0);
        chk("latch_no_frame", 32'(vcnt - v0), 32'd0);
        ser_idle = 1'b1;
        wait_done(5, "idle_done");

        wait_pix(1, "rst_reach");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(bus.pix_valid), 32'd0);
        chk("midrst_last", 32'(bus.pix_last), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(bus.pix_data), 32'd0);
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            ok = bus.pix_valid;
        end
        chk("restart_seen", 32'(ok), 32'd1);
        chk("restart_pix0", 32'(bus.pix_data), 32'h00FF00);
        wait_done(250, "restart_done");

        wait_pix(1, "en_reach");
        enable = 1'b0;
        wait_done(250, "en_finish");
        v0 = vcnt;
        repeat (250) @(posedge clk);
        #1;
        chk("en_off_frames", 32'(vcnt - v0), 32'd0);
        chk("en_off_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        target = done_cnt + 12;
        for (int i = 0; i < 6000 && done_cnt < target; i++) begin
            @(posedge clk); #1;
            if (frame_done) begin
                bright_shift = 3'($urandom_range(0, 7));
                hue_speed    = 8'($urandom_range(0, 255));
            end
            bus.pix_ready = $urandom_range(0, 3) != 0;
            ser_idle      = 1'($urandom_range(0, 1));
        end
        chk("rand_frames", 32'(done_cnt >= target), 32'd1);
        bus.pix_ready = 1'b1;
        ser_idle = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
